vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 95 +++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator producing column/row counts and
// registered sync/active/frame-start decodes, all aligned to the same cycle.
// Optional feature: define VGA_TIMING_FRAME_COUNT_EN to add an 8-bit
// o_Frame_Count output that advances on every frame-start pulse.
module vga_timing_gen #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Enable,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_Active,
    output logic       o_Frame_Start
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output logic [7:0] o_Frame_Count
`endif
);

    // Counter limits narrowed to the 10-bit counter width.
    localparam logic [9:0] LAST_COL = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] LAST_ROW = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] ACT_COLS = 10'(ACTIVE_COLS);
    localparam logic [9:0] ACT_ROWS = 10'(ACTIVE_ROWS);

    logic [9:0] col_reg, row_reg;
    logic [9:0] col_next, row_next;
    logic       hsync_reg, vsync_reg, active_reg, frame_start_reg;
    logic       col_wrap, frame_wrap;
    logic       hsync_next, vsync_next;

    // Next-count computation; decodes are taken from the next counts so the
    // registered decodes line up with the registered counts.
    always_comb begin
        col_wrap   = (col_reg == LAST_COL);
        frame_wrap = col_wrap && (row_reg == LAST_ROW);
        col_next   = col_wrap ? 10'd0 : col_reg + 10'd1;
        row_next   = row_reg;
        if (col_wrap) begin
            row_next = (row_reg == LAST_ROW) ? 10'd0 : row_reg + 10'd1;
        end
        hsync_next = (col_next < ACT_COLS);
        vsync_next = (row_next < ACT_ROWS);
    end

    // Counter and decode registers; reset lands on (0,0), which is active.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            col_reg         <= 10'd0;
            row_reg         <= 10'd0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            active_reg      <= 1'b1;
            frame_start_reg <= 1'b0;
        end else if (i_Enable) begin
            col_reg         <= col_next;
            row_reg         <= row_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            active_reg      <= hsync_next && vsync_next;
            frame_start_reg <= frame_wrap;
        end else begin
            frame_start_reg <= 1'b0;
        end
    end

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [7:0] frame_cnt_reg;

    // Frame counter advances on the same edge that raises o_Frame_Start.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            frame_cnt_reg <= 8'd0;
        end else if (i_Enable && frame_wrap) begin
            frame_cnt_reg <= frame_cnt_reg + 8'd1;
        end
    end

    assign o_Frame_Count = frame_cnt_reg;
`endif

    assign o_Col_Count   = col_reg;
    assign o_Row_Count   = row_reg;
    assign o_HSync       = hsync_reg;
    assign o_VSync       = vsync_reg;
    assign o_Active      = active_reg;
    assign o_Frame_Start = frame_start_reg;

endmodule
